// File: rtl/load_store_sched.sv
// rtl/load_store_sched.sv - round-robin load/store burst scheduler on a shared bounded level
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   req    per-requester burst request, sampled only while idle
//   dir    per-requester direction, 1 = load (+1/step), 0 = store (-1/step)
//   len    per-requester burst length, requester i at [i*LBITS +: LBITS]
//   gnt    one-hot grant, held for the whole burst
//   busy   high while a burst is owned
//   done   one-cycle pulse at burst end
//   abort  valid with done: burst was truncated by the 0 or N bound
//   level  shared level, always within [0, N]
//   full   level == N
//   empty  level == 0
module load_store_sched #(
  parameter int N     = 400000,
  parameter int CBITS = 19,
  parameter int NREQ  = 4,
  parameter int LBITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       dir,
  input  logic [NREQ*LBITS-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic                  abort,
  output logic [CBITS-1:0]      level,
  output logic                  full,
  output logic                  empty
);

  localparam int               IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CBITS-1:0] LMAX  = CBITS'(N);
  localparam logic [IW-1:0]    ILAST = IW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [IW-1:0]    rr, rr_n;
  logic [IW-1:0]    idx, idx_n;
  logic             cdir, cdir_n;
  logic [LBITS-1:0] rem, rem_n;
  logic [NREQ-1:0]  gnt_n;
  logic             busy_n, done_n, abort_n;
  logic [CBITS-1:0] level_n;

  logic             found;
  logic [IW-1:0]    pick;

  // First requester at or after the rr pointer, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(rr) + k) % NREQ]) begin
        found = 1'b1;
        pick  = IW'((int'(rr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_n = state;
    level_n = level;
    gnt_n   = gnt;
    busy_n  = busy;
    done_n  = 1'b0;
    abort_n = 1'b0;
    rr_n    = rr;
    idx_n   = idx;
    cdir_n  = cdir;
    rem_n   = rem;

    unique case (state)
      IDLE: begin
        if (found) begin
          state_n     = RUN;
          gnt_n       = '0;
          gnt_n[pick] = 1'b1;
          busy_n      = 1'b1;
          idx_n       = pick;
          cdir_n      = dir[pick];
          rem_n       = len[pick*LBITS +: LBITS];
        end
      end

      RUN: begin
        if (rem == '0) begin
          state_n = DONE;
          gnt_n   = '0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else if ((cdir && level == LMAX) || (!cdir && level == '0)) begin
          // Bound reached with steps still owed: stop here, level untouched.
          state_n = DONE;
          gnt_n   = '0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          abort_n = 1'b1;
        end else begin
          level_n = cdir ? level + CBITS'(1) : level - CBITS'(1);
          rem_n   = rem - LBITS'(1);
          // Last step completes on the same edge, saving a cycle per burst.
          if (rem == LBITS'(1)) begin
            state_n = DONE;
            gnt_n   = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end

      DONE: begin
        state_n = IDLE;
        rr_n    = (idx == ILAST) ? '0 : idx + IW'(1);
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      level <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      abort <= 1'b0;
      rr    <= '0;
      idx   <= '0;
      cdir  <= 1'b0;
      rem   <= '0;
    end else begin
      state <= state_n;
      level <= level_n;
      gnt   <= gnt_n;
      busy  <= busy_n;
      done  <= done_n;
      abort <= abort_n;
      rr    <= rr_n;
      idx   <= idx_n;
      cdir  <= cdir_n;
      rem   <= rem_n;
    end
  end

  assign full  = (level == LMAX);
  assign empty = (level == '0);

endmodule

// File: tb/tb_load_store_sched.sv
// tb/tb_load_store_sched.sv - self-checking bench for load_store_sched
module tb_load_store_sched;

  localparam int N     = 10;
  localparam int CBITS = 4;
  localparam int NREQ  = 4;
  localparam int LBITS = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ-1:0]       dir = '0;
  logic [NREQ*LBITS-1:0] len = '0;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic                  abort;
  logic [CBITS-1:0]      level;
  logic                  full;
  logic                  empty;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Transaction-level model: only the level value and the round-robin start index.
  int m_level = 0;
  int m_rr    = 0;

  load_store_sched #(
    .N(N), .CBITS(CBITS), .NREQ(NREQ), .LBITS(LBITS)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .dir(dir), .len(len),
    .gnt(gnt), .busy(busy), .done(done), .abort(abort),
    .level(level), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one burst from IDLE and checks every cycle until the DUT is idle again.
  task automatic burst(input logic [NREQ-1:0] rq, input logic [NREQ-1:0] dr,
                       input logic [NREQ*LBITS-1:0] ln);
    int   w, l, d, steps, r, start, lv, mk;
    logic ab;
    w = -1;
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && rq[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
    l     = int'(ln[w*LBITS +: LBITS]);
    d     = int'(dr[w]);
    start = m_level;
    if (d != 0) steps = (l < N - start) ? l : N - start;
    else        steps = (l < start) ? l : start;
    ab = (steps < l);
    r  = (ab || l == 0) ? steps + 1 : steps;

    req = rq; dir = dr; len = ln;
    @(posedge clk); #1;
    chk("grant", gnt, 32'(1) << w);
    chk("busy_at_grant", busy, 1);
    chk("no_done_at_grant", done, 0);

    for (int k = 1; k <= r; k++) begin
      req = NREQ'($urandom);
      dir = NREQ'($urandom);
      len = (NREQ*LBITS)'($urandom);
      @(posedge clk); #1;
      mk = (k < steps) ? k : steps;
      lv = (d != 0) ? start + mk : start - mk;
      if (k < r) begin
        chk("gnt_held", gnt, 32'(1) << w);
        chk("busy_held", busy, 1);
        chk("no_early_done", done, 0);
        chk("level_step", level, lv);
      end else begin
        chk("done_pulse", done, 1);
        chk("abort_flag", abort, ab);
        chk("gnt_cleared", gnt, 0);
        chk("busy_cleared", busy, 0);
        chk("level_final", level, lv);
      end
    end

    req = '0;
    @(posedge clk); #1;
    chk("done_dropped", done, 0);
    chk("abort_dropped", abort, 0);
    chk("full_flag", full, (lv == N) ? 1 : 0);
    chk("empty_flag", empty, (lv == 0) ? 1 : 0);

    m_level = lv;
    m_rr    = (w + 1) % NREQ;
  endtask

  initial begin
    int w;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", level, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_abort", abort, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    #2 rst = 1'b1;

    burst(4'b0001, 4'b0001, 16'h0005);   // load 5 -> 5
    burst(4'b0010, 4'b0000, 16'h0080);   // store 8 from 5 -> abort at 0
    burst(4'b0100, 4'b0100, 16'h0800);   // load 8 -> 8
    burst(4'b1000, 4'b1000, 16'h5000);   // load 5 from 8 -> abort at 10
    burst(4'b0001, 4'b0000, 16'h0000);   // len 0

    for (int i = 0; i < 40; i++)
      burst(NREQ'($urandom_range(1, 15)), NREQ'($urandom), (NREQ*LBITS)'($urandom));

    burst(4'b1111, 4'b0000, 16'hFFFF);   // drain to 0
    burst(4'b0001, 4'b0001, 16'h0001);   // level 1, rr -> 1

    // Reset in the middle of a burst at level 3.
    req = 4'b0010; dir = 4'b0010; len = 16'h0040;
    @(posedge clk); #1;
    chk("mid_grant", gnt, 4'b0010);
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_level", level, 3);
    rst = 1'b0;
    #1;
    chk("mid_rst_level", level, 0);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_empty", empty, 1);
    @(posedge clk); #1;
    chk("mid_rst_no_done", done, 0);
    #2 rst = 1'b1;
    m_level = 0;
    m_rr    = 0;

    // Continuous requests from everyone, one-step loads: rotation 0,1,2,3,0.
    req = 4'b1111; dir = 4'b1111; len = 16'h1111;
    for (int g = 0; g < 5; g++) begin
      w = (m_rr + g) % NREQ;
      @(posedge clk); #1;
      chk("rr_grant", gnt, 32'(1) << w);
      chk("rr_busy", busy, 1);
      @(posedge clk); #1;
      chk("rr_done", done, 1);
      chk("rr_abort", abort, 0);
      chk("rr_gnt_off", gnt, 0);
      chk("rr_level", level, m_level + g + 1);
      @(posedge clk); #1;
      chk("rr_gap_gnt", gnt, 0);
      chk("rr_gap_done", done, 0);
    end
    req = '0;
    m_level = m_level + 5;
    m_rr    = (m_rr + 5) % NREQ;
    @(posedge clk); #1;
    chk("rr_idle_level", level, m_level);
    chk("rr_idle_gnt", gnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/load_store_sched.md
Name: load_store_sched

Overview:
- Shared-resource scheduler for the load/store fill-level counter (the 0..N volume accumulator).
- Arbitrates NREQ requesters, each asking for a burst of unit fill (load) or drain (store) steps on one shared level register.
- Round-robin fairness across requesters.
- Enforces the 0 and N bounds and reports the resulting level, full and empty to the rest of the design.

Parameters:
- N, 400000, level capacity (upper bound of level).
- CBITS, 19, level width; requires 2^CBITS > N.
- NREQ, 4, number of requesters (>=2).
- LBITS, 8, burst length field width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester burst request.
- dir  input  NREQ  per-requester direction: 1 = load (+1/step), 0 = store (-1/step).
- len  input  NREQ*LBITS  per-requester burst length; requester i uses bits [i*LBITS +: LBITS].
- gnt  output  NREQ  one-hot grant, held for the whole burst.
- busy  output  1  high while a burst is owned (RUN state).
- done  output  1  one-cycle pulse at burst end.
- abort  output  1  valid with done; burst was truncated by a bound.
- level  output  CBITS  current shared level.
- full  output  1  level == N.
- empty  output  1  level == 0.

Behaviour:
- Reset (rst low, async) values:
  - state = IDLE, level = 0, gnt = 0, busy = 0, done = 0, abort = 0.
  - rr pointer = 0, full = 0, empty = 1.
  - Reset mid-burst discards the burst with no completion pulse.
- FSM states: IDLE, RUN, DONE. All outputs are registered except full and empty, which decode level combinationally.
- IDLE:
  - On an edge with any req bit set, select the first set bit at or after the rr pointer, wrapping modulo NREQ.
  - Set gnt to that bit, set busy = 1, latch dir[i] and len[i] into internal regs, go to RUN.
  - With no req bit set, stay in IDLE.
- RUN, evaluated each edge using the remaining count rem:
  - rem == 0 (including len = 0 at grant): go to DONE, done = 1, abort = 0; no level change.
  - Load with level == N, or store with level == 0: go to DONE, done = 1, abort = 1; level unchanged.
  - Otherwise: level ±1 and rem - 1. If this was the last step (rem was 1), go to DONE with done = 1, abort = 0 on the same edge.
  - Any transition to DONE clears gnt and busy.
- DONE:
  - One cycle only; next edge: done = 0, abort = 0, go to IDLE.
  - The rr pointer advances to (granted index + 1) mod NREQ on this edge.
- Timing: grant at edge t0 → L level steps on edges t0+1..t0+L → done high in cycle t0+L → earliest next grant at edge t0+L+2.
- Request handling:
  - req is only sampled in IDLE.
  - Dropping req during RUN does not shorten the burst.
  - dir and len changes after the grant are ignored.
- Arithmetic:
  - level never leaves [0, N]; no wrap.
  - rem is LBITS wide, so the maximum burst is 2^LBITS - 1 steps.

Test Plan:
- Reset, then req = 0001, dir[0] = 1, len[0] = 5 → gnt = 0001 for 5 cycles; level = 5; one done pulse with abort = 0; busy low after.
- From level 5: req = 0010, dir[1] = 0, len[1] = 8 → level steps down to 0 after 5 steps; next edge done = 1, abort = 1; empty = 1.
- N = 10 build: fill from 8 with len = 5 → level stops at 10; full = 1; abort = 1; gnt held 3 cycles.
- Continuous req = 1111 with len = 1 each → grants in order 0001, 0010, 0100, 1000, 0001; each grant followed by done one cycle later; gap of one cycle between grants.
- len = 0 granted → done next edge, abort = 0, level unchanged.
- rst asserted low mid-burst at level 3 → immediately level = 0, gnt = 0, busy = 0, no done; after release, rr = 0 so requester 0 wins first.
